// File: rtl/bp_update_arb_if.sv
// bp_update_arb_if: branch-resolution requests in, predictor update channel out
interface bp_update_arb_if #(parameter int NREQ = 2);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_mis;
  logic [NREQ-1:0]       req_ep;
  logic [NREQ-1:0][6:0]  req_id;
  logic [NREQ-1:0][63:0] req_pc;
  logic [NREQ-1:0][63:0] req_npc;
  logic [NREQ-1:0][1:0]  req_pat;
  logic [NREQ-1:0]       req_ready;
  logic                  redir;
  logic                  reinf;
  logic [63:0]           upc;
  logic [63:0]           unpc;
  logic [1:0]            upat;
  logic                  epoch;
  modport master (output req_valid, req_mis, req_ep, req_id, req_pc, req_npc, req_pat,
                  input req_ready, redir, reinf, upc, unpc, upat, epoch);
  modport slave  (input req_valid, req_mis, req_ep, req_id, req_pc, req_npc, req_pat,
                  output req_ready, redir, reinf, upc, unpc, upat, epoch);
endinterface

// File: rtl/bp_update_arb.sv
// bp_update_arb: oldest-first mispredict redirect, reinforce FIFO drained when idle
module bp_update_arb #(
  parameter int NREQ   = 2,
  parameter int QDEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  bp_update_arb_if.slave bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam int RW = NREQ > 1 ? $clog2(NREQ) : 1;
  function automatic logic older(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] d;
    d = b - a;
    return d != '0 && !d[6];
  endfunction
  logic [63:0]     pc_q [QDEPTH];
  logic [1:0]      pat_q [QDEPTH];
  logic [6:0]      id_q [QDEPTH];
  logic [QDEPTH-1:0] vld_q, vld_d;
  logic [AW:0]     wp_q, rp_q, cnt;
  logic [RW-1:0]   rr_q, rr_d, msel, gsel;
  logic            ep_q, redir_q, reinf_q, redir_d, reinf_d;
  logic [63:0]     upc_q, unpc_q, upc_d, unpc_d;
  logic [1:0]      upat_q, upat_d;
  logic [NREQ-1:0] live, cand, rdy;
  logic            mis_any, gnt, full, push, pop;
  logic [6:0]      mid;
  logic [AW-1:0]   hd, wa;
  int              idx;
  always_comb begin
    mis_any = 1'b0;
    msel = '0;
    gnt = 1'b0;
    gsel = '0;
    idx = 0;
    live = bus.req_valid & ~(bus.req_ep ^ {NREQ{ep_q}});
    for (int i = 0; i < NREQ; i++)
      if (live[i] && bus.req_mis[i] && (!mis_any || older(bus.req_id[i], bus.req_id[msel]))) begin
        mis_any = 1'b1;
        msel = RW'(i);
      end
    mid = bus.req_id[msel];
    for (int i = 0; i < NREQ; i++)
      cand[i] = live[i] && !bus.req_mis[i] && !(mis_any && older(mid, bus.req_id[i]));
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!gnt && cand[idx]) begin
        gnt = 1'b1;
        gsel = RW'(idx);
      end
    end
    cnt = wp_q - rp_q;
    full = cnt == (AW+1)'(QDEPTH);
    push = gnt && !full;
    pop = !mis_any && cnt != '0;
    hd = rp_q[AW-1:0];
    wa = wp_q[AW-1:0];
    // everything live is consumed except reinforces still waiting for a FIFO slot
    for (int i = 0; i < NREQ; i++)
      rdy[i] = (bus.req_valid[i] && !live[i]) || (live[i] && !cand[i]) || (push && gsel == RW'(i));
    for (int j = 0; j < QDEPTH; j++)
      vld_d[j] = vld_q[j] && !(mis_any && older(mid, id_q[j]));
    if (push) vld_d[wa] = 1'b1;
    rr_d = push ? RW'((int'(gsel) + 1) % NREQ) : rr_q;
    redir_d = mis_any;
    reinf_d = !mis_any && pop && vld_q[hd];
    upc_d = mis_any ? bus.req_pc[msel] : reinf_d ? pc_q[hd] : upc_q;
    unpc_d = mis_any ? bus.req_npc[msel] : reinf_d ? 64'h0 : unpc_q;
    upat_d = mis_any ? bus.req_pat[msel] : reinf_d ? pat_q[hd] : upat_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      rr_q <= '0;
      ep_q <= 1'b0;
      redir_q <= 1'b0;
      reinf_q <= 1'b0;
      upc_q <= '0;
      unpc_q <= '0;
      upat_q <= '0;
    end else begin
      vld_q <= vld_d;
      wp_q <= wp_q + (AW+1)'(push);
      rp_q <= rp_q + (AW+1)'(pop);
      rr_q <= rr_d;
      ep_q <= ep_q ^ mis_any;
      redir_q <= redir_d;
      reinf_q <= reinf_d;
      upc_q <= upc_d;
      unpc_q <= unpc_d;
      upat_q <= upat_d;
    end
  always_ff @(posedge clk)
    if (push) begin
      pc_q[wa] <= bus.req_pc[gsel];
      pat_q[wa] <= bus.req_pat[gsel];
      id_q[wa] <= bus.req_id[gsel];
    end
  assign bus.req_ready = rdy;
  assign bus.redir = redir_q;
  assign bus.reinf = reinf_q;
  assign bus.upc = upc_q;
  assign bus.unpc = unpc_q;
  assign bus.upat = upat_q;
  assign bus.epoch = ep_q;
endmodule
